division_seq: RTL and testbench

- Parametrised, multi-cycle restoring divider. It is the clocked successor to the team's combinational 8-bit divider.
- Computes quotient and remainder of a WIDTH-bit dividend by a WIDTH-bit divisor, one quotient bit per clock.
- Uses a start/ready/done handshake and flags divide-by-zero.
- Sits in the ALU datapath as the DIV/MOD execution unit. The ALU controller stalls on ready.

---
 rtl/division_seq.sv | 154 +++++++++++++++
 tb/tb_division_seq.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/division_seq.sv
// division_seq: multi-cycle restoring divider, one quotient bit per clock.
// Optional signed operation is enabled by defining DIVISION_SEQ_SIGNED_EN.
module division_seq #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
`ifdef DIVISION_SEQ_SIGNED_EN
    input  logic             signed_mode,
`endif
    output logic             ready,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        FINISH
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] prem;
    logic [WIDTH-1:0] dvd;
    logic [WIDTH-1:0] dvs;

    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   diff;
    logic             qbit;
    logic [WIDTH-1:0] next_prem;
    logic [WIDTH-1:0] next_q;
    logic [WIDTH-1:0] fin_q;
    logic [WIDTH-1:0] fin_r;

`ifdef DIVISION_SEQ_SIGNED_EN
    logic sgn_a;
    logic sgn_b;
    logic neg_q;
    logic neg_r;
`endif

    // Operand magnitudes presented to the unsigned iteration
    always_comb begin
`ifdef DIVISION_SEQ_SIGNED_EN
        sgn_a = signed_mode & a[WIDTH-1];
        sgn_b = signed_mode & b[WIDTH-1];
        op_a  = sgn_a ? (~a + 1'b1) : a;
        op_b  = sgn_b ? (~b + 1'b1) : b;
`else
        op_a = a;
        op_b = b;
`endif
    end

    // One restoring step; the borrow out of the
    // WIDTH+1 bit subtract is the inverted quotient bit
    always_comb begin
        shifted   = {prem, dvd[WIDTH-1]};
        diff      = shifted - {1'b0, dvs};
        qbit      = ~diff[WIDTH];
        next_prem = qbit ? diff[WIDTH-1:0]
                         : shifted[WIDTH-1:0];
        next_q    = {dvd[WIDTH-2:0], qbit};
        fin_q     = next_q;
        fin_r     = next_prem;
`ifdef DIVISION_SEQ_SIGNED_EN
        if (neg_q) fin_q = ~next_q + 1'b1;
        if (neg_r) fin_r = ~next_prem + 1'b1;
`endif
    end

    assign ready = (state == IDLE);

    // Control FSM and datapath registers; the dividend
    // register doubles as the quotient shift register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            done        <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
            cnt         <= '0;
            prem        <= '0;
            dvd         <= '0;
            dvs         <= '0;
`ifdef DIVISION_SEQ_SIGNED_EN
            neg_q       <= 1'b0;
            neg_r       <= 1'b0;
`endif
        end else begin
            unique case (state)
                IDLE: begin
                    if (start) begin
                        dvd <= op_a;
                        dvs <= op_b;
`ifdef DIVISION_SEQ_SIGNED_EN
                        neg_q <= sgn_a ^ sgn_b;
                        neg_r <= sgn_a;
`endif
                        if (b == '0) begin
                            quotient    <= '1;
                            remainder   <= a;
                            div_by_zero <= 1'b1;
                            state       <= FINISH;
                        end else begin
                            cnt   <= '0;
                            prem  <= '0;
                            state <= BUSY;
                        end
                    end
                end
                BUSY: begin
                    prem <= next_prem;
                    dvd  <= next_q;
                    cnt  <= cnt + 1'b1;
                    if (cnt == LAST) begin
                        quotient    <= fin_q;
                        remainder   <= fin_r;
                        div_by_zero <= 1'b0;
                        done        <= 1'b1;
                        state       <= FINISH;
                    end
                end
                FINISH: begin
                    // Divide-by-zero arrives with done low and
                    // spends one extra cycle here raising it
                    if (done) begin
                        done  <= 1'b0;
                        state <= IDLE;
                    end else begin
                        done <= 1'b1;
                    end
                end
                default: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_division_seq.sv
// tb_division_seq: directed checks of division_seq at WIDTH 8 and 16.
// Signed cases are exercised when DIVISION_SEQ_SIGNED_EN is defined.
module tb_division_seq;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start8 = 1'b0;
  logic [7:0]  a8 = '0;
  logic [7:0]  b8 = '0;
  logic        rdy8, done8, z8;
  logic [7:0]  q8, r8;
  logic        start16 = 1'b0;
  logic [15:0] a16 = '0;
  logic [15:0] b16 = '0;
  logic        rdy16, done16, z16;
  logic [15:0] q16, r16;
  logic        signed_mode = 1'b0;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  division_seq #(.WIDTH(8)) u8 (
    .clk(clk), .rst(rst), .start(start8),
    .a(a8), .b(b8),
`ifdef DIVISION_SEQ_SIGNED_EN
    .signed_mode(signed_mode),
`endif
    .ready(rdy8), .done(done8),
    .quotient(q8), .remainder(r8),
    .div_by_zero(z8)
  );

  division_seq #(.WIDTH(16)) u16 (
    .clk(clk), .rst(rst), .start(start16),
    .a(a16), .b(b16),
`ifdef DIVISION_SEQ_SIGNED_EN
    .signed_mode(signed_mode),
`endif
    .ready(rdy16), .done(done16),
    .quotient(q16), .remainder(r16),
    .div_by_zero(z16)
  );

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d",
             tag, obs, exp);
    end
  endtask

  task automatic op8(input logic [7:0] ai,
                     input logic [7:0] bi,
                     input logic [7:0] eq,
                     input logic [7:0] er,
                     input logic ez,
                     input int lat);
    int n;
    @(negedge clk);
    start8 = 1'b1;
    a8 = ai;
    b8 = bi;
    @(negedge clk);
    start8 = 1'b0;
    a8 = ~ai;
    b8 = ~bi;
    n = 1;
    chk("ready_drop8", rdy8, 1'b0);
    while (!done8 && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("timeout8", done8, 1'b1);
    chk("latency8", n, lat);
    chk("quot8", q8, eq);
    chk("rem8", r8, er);
    chk("dbz8", z8, ez);
    @(negedge clk);
    chk("done_pulse8", done8, 1'b0);
    chk("ready_back8", rdy8, 1'b1);
    chk("hold_quot8", q8, eq);
  endtask

  task automatic op16(input logic [15:0] ai,
                      input logic [15:0] bi,
                      input logic [15:0] eq,
                      input logic [15:0] er);
    int n;
    @(negedge clk);
    start16 = 1'b1;
    a16 = ai;
    b16 = bi;
    @(negedge clk);
    start16 = 1'b0;
    a16 = ~ai;
    n = 1;
    while (!done16 && n < 60) begin
      @(negedge clk);
      n++;
    end
    chk("timeout16", done16, 1'b1);
    chk("latency16", n, 17);
    chk("quot16", q16, eq);
    chk("rem16", r16, er);
    chk("dbz16", z16, 1'b0);
    @(negedge clk);
    chk("ready_back16", rdy16, 1'b1);
  endtask

  initial begin
    int n;
    int hits;
    int pos;
    logic [7:0] ai, bi, gq, gr;

    repeat (2) @(negedge clk);
    chk("rst_ready", rdy8, 1'b1);
    chk("rst_done", done8, 1'b0);
    chk("rst_quot", q8, 8'd0);
    chk("rst_rem", r8, 8'd0);
    chk("rst_dbz", z8, 1'b0);
    rst = 1'b0;

    op8(8'd200, 8'd7, 8'd28, 8'd4, 1'b0, 9);
    op8(8'd55, 8'd0, 8'd255, 8'd55, 1'b1, 2);
    op8(8'd9, 8'd3, 8'd3, 8'd0, 1'b0, 9);
    op8(8'd255, 8'd1, 8'd255, 8'd0, 1'b0, 9);
    op8(8'd0, 8'd5, 8'd0, 8'd0, 1'b0, 9);
    op8(8'd5, 8'd200, 8'd0, 8'd5, 1'b0, 9);
    op8(8'd255, 8'd255, 8'd1, 8'd0, 1'b0, 9);
    op8(8'd254, 8'd255, 8'd0, 8'd254, 1'b0, 9);

    op16(16'd65535, 16'd255, 16'd257, 16'd0);
    op16(16'd5, 16'd9, 16'd0, 16'd5);

    @(negedge clk);
    start8 = 1'b1;
    a8 = 8'd100;
    b8 = 8'd3;
    @(negedge clk);
    start8 = 1'b0;
    n = 1;
    repeat (2) begin
      @(negedge clk);
      n++;
    end
    start8 = 1'b1;
    a8 = 8'd1;
    b8 = 8'd1;
    @(negedge clk);
    n++;
    start8 = 1'b0;
    while (!done8 && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("ign_timeout", done8, 1'b1);
    chk("ign_latency", n, 9);
    chk("ign_quot", q8, 8'd33);
    chk("ign_rem", r8, 8'd1);
    @(negedge clk);

    @(negedge clk);
    start8 = 1'b1;
    a8 = 8'd200;
    b8 = 8'd7;
    @(negedge clk);
    start8 = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("mid_rst_ready", rdy8, 1'b1);
    chk("mid_rst_done", done8, 1'b0);
    chk("mid_rst_quot", q8, 8'd0);
    chk("mid_rst_rem", r8, 8'd0);
    chk("mid_rst_dbz", z8, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    hits = 0;
    repeat (15) begin
      @(negedge clk);
      if (done8) hits++;
    end
    chk("mid_rst_no_done", hits, 0);
    chk("mid_rst_idle", rdy8, 1'b1);

    start8 = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      ai = 8'($urandom_range(0, 255));
      bi = 8'($urandom_range(1, 255));
      a8 = ai;
      b8 = bi;
      hits = 0;
      pos = 0;
      gq = '0;
      gr = '0;
      for (int k = 1; k <= 10; k++) begin
        @(negedge clk);
        if (done8) begin
          hits++;
          pos = k;
          gq = q8;
          gr = r8;
        end
      end
      chk("stream_dones", hits, 1);
      chk("stream_pos", pos, 9);
      chk("stream_quot", gq, 8'(ai / bi));
      chk("stream_rem", gr, 8'(ai % bi));
    end
    start8 = 1'b0;

`ifdef DIVISION_SEQ_SIGNED_EN
    signed_mode = 1'b1;
    op8(8'h9C, 8'd7, 8'hF2, 8'hFE, 1'b0, 9);
    op8(8'h80, 8'hFF, 8'h80, 8'h00, 1'b0, 9);
    op8(8'd100, 8'hF9, 8'hF2, 8'h02, 1'b0, 9);
    op8(8'h9C, 8'h00, 8'hFF, 8'h9C, 1'b1, 2);
    signed_mode = 1'b0;
`endif

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
